// File: rtl/rca_serial_accum_pkg.sv
// Shared constants, FSM state type and sizing helper for the nibble-serial accumulating adder.
package rca_serial_accum_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // A single-nibble build still needs a 1-bit counter.
    function automatic int cnt_width(input int nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

endpackage

// File: rtl/rca_serial_accum_if.sv
// Request/result bundle between an operand source and the serial adder.
interface rca_serial_accum_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/rca_serial_accum_rc_adder.sv
// Combinational 4-bit ripple-carry adder stage used once per clock by the serial sequencer.
module rca_serial_accum_rc_adder
    import rca_serial_accum_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] s,
    output logic                carry
);

    logic [NIBBLE_W:0] c;

    assign c[0] = cin;

    for (genvar gi = 0; gi < NIBBLE_W; gi++) begin : g_bit
        assign s[gi]    = a[gi] ^ b[gi] ^ c[gi];
        assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
    end

    assign carry = c[NIBBLE_W];

endmodule

// File: rtl/rca_serial_accum.sv
// Wide adder computed one nibble per clock, LSB first, through a single 4-bit ripple stage.
// Result and final carry update only on the completion edge; done pulses for one cycle.
module rca_serial_accum
    import rca_serial_accum_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    rca_serial_accum_if.slave  bus
);

    localparam int NSLICE = WIDTH / NIBBLE_W;
    localparam int CNT_W  = cnt_width(NSLICE);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_q, c_d;
    logic             cout_q, cout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [NIBBLE_W-1:0] nib_s;
    logic                nib_carry;
    logic [WIDTH-1:0]    word;
    logic                accept;
    logic                last;

    assign accept = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign last   = (state_q == S_RUN) && (cnt_q == CNT_W'(NSLICE - 1));

    rca_serial_accum_rc_adder u_rc_adder (
        .a     (a_sh_q[NIBBLE_W-1:0]),
        .b     (b_sh_q[NIBBLE_W-1:0]),
        .cin   (c_q),
        .s     (nib_s),
        .carry (nib_carry)
    );

    // word is the result as it stands after this cycle's nibble is appended at the top.
    if (NSLICE == 1) begin : g_one
        assign word = nib_s;
    end else begin : g_many
        logic [WIDTH-NIBBLE_W-1:0] part_q;

        assign word = {nib_s, part_q};

        always_ff @(posedge clk) begin
            if (rst) begin
                part_q <= '0;
            end else if (state_q == S_RUN) begin
                part_q <= word[WIDTH-1:NIBBLE_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_RUN;
            S_RUN:   if (last)      state_d = S_DONE;
            S_DONE:  state_d = bus.start ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        a_sh_d = a_sh_q;
        b_sh_d = b_sh_q;
        c_d    = c_q;
        cnt_d  = cnt_q;
        sum_d  = sum_q;
        cout_d = cout_q;
        if (accept) begin
            a_sh_d = bus.a;
            b_sh_d = bus.b;
            c_d    = bus.cin;
            cnt_d  = '0;
        end else if (state_q == S_RUN) begin
            a_sh_d = a_sh_q >> NIBBLE_W;
            b_sh_d = b_sh_q >> NIBBLE_W;
            c_d    = nib_carry;
            cnt_d  = cnt_q + 1'b1;
            if (last) begin
                sum_d  = word;
                cout_d = nib_carry;
            end
        end
    end

    always_comb begin
        bus.busy = (state_q == S_RUN);
        bus.done = (state_q == S_DONE);
        bus.sum  = sum_q;
        bus.cout = cout_q;
    end

endmodule

// File: tb/tb_rca_serial_accum.sv
// Bench for the serial adder: directed cases, a 200-operation random run and a 4-bit build.
module tb_rca_serial_accum;

    logic clk;
    logic rst;

    int n_checks;
    int n_errors;
    int n_txn;

    logic [16:0] prev16;
    logic [4:0]  prev4;

    rca_serial_accum_if #(.WIDTH(16)) if16 ();
    rca_serial_accum_if #(.WIDTH(4))  if4 ();

    rca_serial_accum #(.WIDTH(16)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (if16.slave)
    );

    rca_serial_accum #(.WIDTH(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (if4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] ref16(input logic [15:0] a, input logic [15:0] b, input logic cin);
        return 17'(a) + 17'(b) + 17'(cin);
    endfunction

    // Single transaction on the 16-bit unit; leaves the bench #1 after the edge that leaves DONE.
    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic cin);
        logic [16:0] exp;
        int cyc;
        exp = ref16(a, b, cin);
        @(negedge clk);
        if16.start = 1'b1;
        if16.a     = a;
        if16.b     = b;
        if16.cin   = cin;
        @(posedge clk);
        #1;
        if16.start = 1'b0;
        cyc = 0;
        while (!if16.done && cyc < 20) begin
            check("busy_in_run", 64'(if16.busy), 64'd1);
            check("sum_held", 64'({if16.cout, if16.sum}), 64'(prev16));
            @(posedge clk);
            #1;
            cyc++;
        end
        check("latency16", 64'(cyc), 64'd4);
        check("busy_at_done", 64'(if16.busy), 64'd0);
        check("result16", 64'({if16.cout, if16.sum}), 64'(exp));
        $display("txn %0d w16 a=%h b=%h cin=%0d -> cout=%0d sum=%h (exp %h)",
                 n_txn, a, b, cin, if16.cout, if16.sum, exp);
        n_txn++;
        prev16 = exp;
        @(posedge clk);
        #1;
        check("done_one_cycle", 64'(if16.done), 64'd0);
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic cin);
        logic [4:0] exp;
        int cyc;
        exp = 5'(a) + 5'(b) + 5'(cin);
        @(negedge clk);
        if4.start = 1'b1;
        if4.a     = a;
        if4.b     = b;
        if4.cin   = cin;
        @(posedge clk);
        #1;
        if4.start = 1'b0;
        cyc = 0;
        while (!if4.done && cyc < 20) begin
            check("busy4_in_run", 64'(if4.busy), 64'd1);
            check("sum4_held", 64'({if4.cout, if4.sum}), 64'(prev4));
            @(posedge clk);
            #1;
            cyc++;
        end
        check("latency4", 64'(cyc), 64'd1);
        check("result4", 64'({if4.cout, if4.sum}), 64'(exp));
        $display("txn %0d w4 a=%h b=%h cin=%0d -> cout=%0d sum=%h (exp %h)",
                 n_txn, a, b, cin, if4.cout, if4.sum, exp);
        n_txn++;
        prev4 = exp;
        @(posedge clk);
        #1;
        check("done4_one_cycle", 64'(if4.done), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [16:0] exp1;
        logic [16:0] exp2;
        int cyc;
        int done_seen;

        n_checks  = 0;
        n_errors  = 0;
        n_txn     = 0;
        prev16    = '0;
        prev4     = '0;
        rst       = 1'b1;
        if16.start = 1'b0; if16.a = '0; if16.b = '0; if16.cin = 1'b0;
        if4.start  = 1'b0; if4.a  = '0; if4.b  = '0; if4.cin  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(if16.busy), 64'd0);
        check("rst_done", 64'(if16.done), 64'd0);
        check("rst_sum",  64'({if16.cout, if16.sum}), 64'd0);
        check("rst4_sum", 64'({if4.busy, if4.done, if4.cout, if4.sum}), 64'd0);
        rst = 1'b0;

        run16(16'h1234, 16'h4321, 1'b0);
        run16(16'hFFFF, 16'h0001, 1'b0);
        run16(16'hFFFF, 16'hFFFF, 1'b1);

        // start held through RUN with changing operands: only the DONE-cycle start counts.
        exp1 = ref16(16'hABCD, 16'h1111, 1'b0);
        exp2 = ref16(16'h0F0F, 16'h7070, 1'b1);
        @(negedge clk);
        if16.start = 1'b1; if16.a = 16'hABCD; if16.b = 16'h1111; if16.cin = 1'b0;
        @(posedge clk);
        #1;
        if16.a = 16'h0F0F; if16.b = 16'h7070; if16.cin = 1'b1;
        cyc = 0;
        while (!if16.done && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("b2b_latency1", 64'(cyc), 64'd4);
        check("b2b_result1", 64'({if16.cout, if16.sum}), 64'(exp1));
        @(posedge clk);
        #1;
        if16.start = 1'b0;
        cyc = 1;
        check("b2b_busy", 64'(if16.busy), 64'd1);
        while (!if16.done && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("b2b_spacing", 64'(cyc), 64'd5);
        check("b2b_result2", 64'({if16.cout, if16.sum}), 64'(exp2));
        $display("txn %0d w16 back-to-back results %h then %h", n_txn, exp1, exp2);
        n_txn++;
        prev16 = exp2;
        @(posedge clk);
        #1;
        check("b2b_done_drop", 64'(if16.done), 64'd0);

        // Reset sampled at the end of the second RUN cycle discards the operation.
        @(negedge clk);
        if16.start = 1'b1; if16.a = 16'h5555; if16.b = 16'h2222; if16.cin = 1'b0;
        @(posedge clk);
        #1;
        if16.start = 1'b0;
        @(posedge clk);
        #1;
        check("pre_rst_busy", 64'(if16.busy), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrun_rst_state", 64'({if16.busy, if16.done, if16.cout, if16.sum}), 64'd0);
        prev16 = '0;
        done_seen = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (if16.done || if16.busy) done_seen++;
        end
        check("no_done_after_rst", 64'(done_seen), 64'd0);
        $display("txn %0d w16 aborted by reset", n_txn);
        n_txn++;
        run16(16'h0008, 16'h0008, 1'b0);

        for (int i = 0; i < 200; i++) begin
            run16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        end

        prev4 = '0;
        run4(4'hF, 4'h1, 1'b0);
        run4(4'h7, 4'h8, 1'b1);
        for (int i = 0; i < 8; i++) begin
            run4(4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
